// File: rtl/prnd_input_conditioner.sv
// Conditions the raw {P,R,N,D} selector pins into a validated one-hot gear selection.
// Pipeline: 2-FF synchroniser -> per-line debounce -> one-hot validation FSM.
module prnd_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FAULT_CYCLES    = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] sw_raw,
    output logic [3:0] sel,
    output logic       sel_chg,
    output logic       fault
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
    localparam int TCNT_W = $clog2(FAULT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(FAULT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_OK,
        S_TRANSIT,
        S_FAULT
    } state_t;

    logic [3:0]       sync_s1_reg;
    logic [3:0]       sync_s2_reg;
    logic [3:0]       db_reg;
    logic [3:0]       db_next;
    logic [CNT_W-1:0] cnt_reg  [4];
    logic [CNT_W-1:0] cnt_next [4];

    state_t              state_reg, state_next;
    logic [TCNT_W-1:0]   tcnt_reg, tcnt_next;
    logic [3:0]          sel_reg, sel_next;
    logic                sel_chg_reg, sel_chg_next;
    logic                fault_reg, fault_next;

    // Each line flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_debounce
            logic mismatch;
            assign mismatch     = (sync_s2_reg[gi] != db_reg[gi]);
            assign cnt_next[gi] = (!mismatch || cnt_reg[gi] == CNT_LAST)
                                  ? '0 : cnt_reg[gi] + CNT_W'(1);
            assign db_next[gi]  = (mismatch && cnt_reg[gi] == CNT_LAST)
                                  ? sync_s2_reg[gi] : db_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_s1_reg <= '0;
            sync_s2_reg <= '0;
            db_reg      <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_reg[i] <= '0;
            end
        end else begin
            sync_s1_reg <= sw_raw;
            sync_s2_reg <= sync_s1_reg;
            db_reg      <= db_next;
            cnt_reg     <= cnt_next;
        end
    end

    logic code_legal;
    logic code_zero;
    assign code_legal = $onehot(db_reg);
    assign code_zero  = (db_reg == 4'b0000);

    always_comb begin
        state_next   = state_reg;
        tcnt_next    = tcnt_reg;
        sel_next     = sel_reg;
        sel_chg_next = 1'b0;

        // A legal code always wins, from any state; re-selecting the held gear is silent.
        if (code_legal) begin
            state_next = S_OK;
            tcnt_next  = '0;
            if (db_reg != sel_reg) begin
                sel_next     = db_reg;
                sel_chg_next = 1'b1;
            end
        end else begin
            case (state_reg)
                S_OK: begin
                    if (code_zero) begin
                        state_next = S_TRANSIT;
                        tcnt_next  = TCNT_W'(1);
                    end else begin
                        state_next = S_FAULT;
                    end
                end
                S_TRANSIT: begin
                    if (!code_zero || tcnt_reg == TCNT_LAST) begin
                        state_next = S_FAULT;
                    end else begin
                        tcnt_next = tcnt_reg + TCNT_W'(1);
                    end
                end
                S_FAULT: begin
                    state_next = S_FAULT;
                end
                default: begin
                    state_next = S_FAULT;
                end
            endcase
        end

        fault_next = (state_next == S_FAULT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_OK;
            tcnt_reg    <= '0;
            sel_reg     <= 4'b1000;
            sel_chg_reg <= 1'b0;
            fault_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            tcnt_reg    <= tcnt_next;
            sel_reg     <= sel_next;
            sel_chg_reg <= sel_chg_next;
            fault_reg   <= fault_next;
        end
    end

    assign sel     = sel_reg;
    assign sel_chg = sel_chg_reg;
    assign fault   = fault_reg;

endmodule

// File: tb/tb_prnd_input_conditioner.sv
// Bench for prnd_input_conditioner: directed scenarios plus random pin activity,
// every cycle compared against a behavioural model of the gear-selection rules.
module tb_prnd_input_conditioner;

    localparam int DB = 4;
    localparam int FC = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sw_raw;
    logic [3:0] sel;
    logic       sel_chg;
    logic       fault;

    int checks = 0;
    int errors = 0;

    prnd_input_conditioner #(
        .DEBOUNCE_CYCLES(DB),
        .FAULT_CYCLES   (FC)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .sw_raw (sw_raw),
        .sel    (sel),
        .sel_chg(sel_chg),
        .fault  (fault)
    );

    always #5 clk = ~clk;

    // Behavioural model: pin history, run lengths of disagreement, gear/fault bookkeeping.
    logic [3:0] m_s1, m_s2, m_db, m_sel;
    logic       m_chg, m_fault, m_faulted;
    int         m_run [4];
    int         m_zero_len;

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_db = '0;
        m_sel = 4'b1000; m_chg = 1'b0; m_fault = 1'b0; m_faulted = 1'b0;
        m_zero_len = 0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
    endtask

    task automatic model_step();
        int pop;
        logic [3:0] nd;
        if (reset) begin
            model_reset();
            return;
        end
        pop   = $countones(m_db);
        m_chg = 1'b0;
        if (pop == 1) begin
            if (m_db != m_sel) begin
                m_sel = m_db;
                m_chg = 1'b1;
            end
            m_faulted  = 1'b0;
            m_zero_len = 0;
        end else if (pop > 1) begin
            m_faulted  = 1'b1;
            m_zero_len = 0;
        end else if (!m_faulted) begin
            if (m_zero_len == FC - 1) begin
                m_faulted  = 1'b1;
                m_zero_len = 0;
            end else begin
                m_zero_len++;
            end
        end
        m_fault = m_faulted;
        nd = m_db;
        for (int i = 0; i < 4; i++) begin
            if (m_s2[i] != m_db[i]) begin
                m_run[i]++;
                if (m_run[i] == DB) begin
                    nd[i]    = m_s2[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_db = nd;
        m_s2 = m_s1;
        m_s1 = sw_raw;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic return_park();
        sw_raw = 4'b1000;
        for (int n = 0; n < 16; n++) begin
            tick();
            checks++;
            if ({sel, sel_chg, fault} !== {m_sel, m_chg, m_fault}) begin
                errors++;
                $display("FAIL park_return: got %b expected %b", {sel, sel_chg, fault}, {m_sel, m_chg, m_fault});
            end
        end
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        sw_raw = 4'b1000;
        model_reset();
        #12;
        checks++;
        if ({sel, sel_chg, fault} !== 6'b1000_0_0) begin
            errors++;
            $display("FAIL reset_state: got %b expected %b", {sel, sel_chg, fault}, 6'b1000_0_0);
        end
        tick();
        tick();
        #3 reset = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            checks++;
            if ({sel, sel_chg, fault} !== {m_sel, m_chg, m_fault}) begin
                errors++;
                $display("FAIL reset_model: got %b expected %b", {sel, sel_chg, fault}, {m_sel, m_chg, m_fault});
            end
            checks++;
            if ({sel, sel_chg, fault} !== 6'b1000_0_0) begin
                errors++;
                $display("FAIL reset_park_hold: got %b expected %b", {sel, sel_chg, fault}, 6'b1000_0_0);
            end
        end
        $display("scenario reset: sel=%b fault=%b", sel, fault);
    endtask

    task automatic test_clean_step();
        int lat = 0;
        int pulses = 0;
        sw_raw = 4'b0001;
        for (int n = 1; n <= 20; n++) begin
            tick();
            checks++;
            if ({sel, sel_chg, fault} !== {m_sel, m_chg, m_fault}) begin
                errors++;
                $display("FAIL step_model: got %b expected %b", {sel, sel_chg, fault}, {m_sel, m_chg, m_fault});
            end
            if (sel_chg === 1'b1) pulses++;
            if (lat == 0 && sel === 4'b0001) begin
                lat = n;
                checks++;
                if (sel_chg !== 1'b1) begin
                    errors++;
                    $display("FAIL step_pulse_edge: got %b expected 1", sel_chg);
                end
            end
        end
        checks++;
        if (lat !== 2 + DB + 1) begin
            errors++;
            $display("FAIL step_latency: got %0d expected %0d", lat, 2 + DB + 1);
        end
        checks++;
        if (pulses !== 1) begin
            errors++;
            $display("FAIL step_pulses: got %0d expected 1", pulses);
        end
        $display("scenario clean_step: latency=%0d pulses=%0d", lat, pulses);
    endtask

    task automatic test_bounce();
        logic [3:0] pat [4];
        int pulses = 0;
        pat[0] = 4'b0001; pat[1] = 4'b0000; pat[2] = 4'b0001; pat[3] = 4'b0000;
        return_park();
        for (int n = 0; n < 24; n++) begin
            sw_raw = (n < 4) ? pat[n] : 4'b0001;
            tick();
            checks++;
            if ({sel, sel_chg, fault} !== {m_sel, m_chg, m_fault}) begin
                errors++;
                $display("FAIL bounce_model: got %b expected %b", {sel, sel_chg, fault}, {m_sel, m_chg, m_fault});
            end
            if (sel_chg === 1'b1) pulses++;
        end
        checks++;
        if (sel !== 4'b0001 || pulses !== 1) begin
            errors++;
            $display("FAIL bounce_result: got sel=%b pulses=%0d expected sel=0001 pulses=1", sel, pulses);
        end
        $display("scenario bounce: sel=%b pulses=%0d", sel, pulses);
    endtask

    task automatic test_travel();
        int pulses = 0;
        return_park();
        for (int n = 0; n < 25; n++) begin
            sw_raw = (n < 5) ? 4'b0000 : 4'b0100;
            tick();
            checks++;
            if ({sel, sel_chg, fault} !== {m_sel, m_chg, m_fault}) begin
                errors++;
                $display("FAIL travel_model: got %b expected %b", {sel, sel_chg, fault}, {m_sel, m_chg, m_fault});
            end
            checks++;
            if (fault !== 1'b0 || (sel !== 4'b1000 && sel !== 4'b0100)) begin
                errors++;
                $display("FAIL travel_hold: got sel=%b fault=%b expected sel=1000/0100 fault=0", sel, fault);
            end
            if (sel_chg === 1'b1) pulses++;
        end
        checks++;
        if (sel !== 4'b0100 || pulses !== 1) begin
            errors++;
            $display("FAIL travel_result: got sel=%b pulses=%0d expected sel=0100 pulses=1", sel, pulses);
        end
        $display("scenario travel: sel=%b pulses=%0d", sel, pulses);
    endtask

    task automatic test_fault_timeout();
        int  rise = 0;
        int  exit_edge = 0;
        logic prev_fault;
        return_park();
        sw_raw = 4'b0000;
        for (int n = 1; n <= 20; n++) begin
            tick();
            checks++;
            if ({sel, sel_chg, fault} !== {m_sel, m_chg, m_fault}) begin
                errors++;
                $display("FAIL timeout_model: got %b expected %b", {sel, sel_chg, fault}, {m_sel, m_chg, m_fault});
            end
            if (rise == 0 && fault === 1'b1) rise = n;
        end
        checks++;
        if (rise !== 2 + DB + FC || sel !== 4'b1000) begin
            errors++;
            $display("FAIL timeout_rise: got edge=%0d sel=%b expected edge=%0d sel=1000", rise, sel, 2 + DB + FC);
        end
        sw_raw = 4'b0010;
        prev_fault = fault;
        for (int n = 1; n <= 15; n++) begin
            tick();
            checks++;
            if ({sel, sel_chg, fault} !== {m_sel, m_chg, m_fault}) begin
                errors++;
                $display("FAIL timeout_exit_model: got %b expected %b", {sel, sel_chg, fault}, {m_sel, m_chg, m_fault});
            end
            if (exit_edge == 0 && sel === 4'b0010) begin
                exit_edge = n;
                checks++;
                if (fault !== 1'b0 || prev_fault !== 1'b1 || sel_chg !== 1'b1) begin
                    errors++;
                    $display("FAIL timeout_exit_edge: got fault=%b prev=%b chg=%b expected 0 1 1", fault, prev_fault, sel_chg);
                end
            end
            prev_fault = fault;
        end
        checks++;
        if (exit_edge !== 2 + DB + 1) begin
            errors++;
            $display("FAIL timeout_exit_latency: got %0d expected %0d", exit_edge, 2 + DB + 1);
        end
        $display("scenario fault_timeout: rise=%0d exit=%0d", rise, exit_edge);
    endtask

    task automatic test_multi_reset();
        sw_raw = 4'b0110;
        for (int n = 0; n < 12; n++) begin
            tick();
            checks++;
            if ({sel, sel_chg, fault} !== {m_sel, m_chg, m_fault}) begin
                errors++;
                $display("FAIL multi_model: got %b expected %b", {sel, sel_chg, fault}, {m_sel, m_chg, m_fault});
            end
        end
        checks++;
        if (fault !== 1'b1 || sel !== 4'b0010) begin
            errors++;
            $display("FAIL multi_fault: got sel=%b fault=%b expected sel=0010 fault=1", sel, fault);
        end
        #3 reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({sel, sel_chg, fault} !== 6'b1000_0_0) begin
            errors++;
            $display("FAIL multi_async_reset: got %b expected %b", {sel, sel_chg, fault}, 6'b1000_0_0);
        end
        sw_raw = 4'b1000;
        tick();
        tick();
        #3 reset = 1'b0;
        for (int n = 0; n < 20; n++) begin
            tick();
            checks++;
            if ({sel, sel_chg, fault} !== {m_sel, m_chg, m_fault} || sel_chg !== 1'b0) begin
                errors++;
                $display("FAIL multi_release: got %b expected %b", {sel, sel_chg, fault}, {m_sel, m_chg, m_fault});
            end
        end
        $display("scenario multi_reset: sel=%b fault=%b", sel, fault);
    endtask

    task automatic test_swap();
        int pulses = 0;
        logic saw_fault = 1'b0;
        return_park();
        for (int n = 0; n < 22; n++) begin
            sw_raw = (n < 2) ? 4'b1100 : 4'b0100;
            tick();
            checks++;
            if ({sel, sel_chg, fault} !== {m_sel, m_chg, m_fault}) begin
                errors++;
                $display("FAIL swap_model: got %b expected %b", {sel, sel_chg, fault}, {m_sel, m_chg, m_fault});
            end
            if (sel_chg === 1'b1) pulses++;
            if (fault === 1'b1) saw_fault = 1'b1;
        end
        checks++;
        if (sel !== 4'b0100 || pulses !== 1 || saw_fault !== 1'b1 || fault !== 1'b0) begin
            errors++;
            $display("FAIL swap_result: got sel=%b pulses=%0d saw_fault=%b fault=%b expected 0100 1 1 0",
                     sel, pulses, saw_fault, fault);
        end
        $display("scenario swap: sel=%b pulses=%0d", sel, pulses);
    endtask

    task automatic test_random();
        int cyc = 0;
        while (cyc < 800) begin
            int hold;
            if ($urandom_range(1, 0) == 1) sw_raw = 4'b0001 << $urandom_range(3, 0);
            else                           sw_raw = 4'($urandom_range(15, 0));
            hold = $urandom_range(14, 1);
            for (int h = 0; h < hold; h++) begin
                tick();
                cyc++;
                checks++;
                if ({sel, sel_chg, fault} !== {m_sel, m_chg, m_fault}) begin
                    errors++;
                    $display("FAIL random_model: cycle %0d got %b expected %b", cyc, {sel, sel_chg, fault},
                             {m_sel, m_chg, m_fault});
                end
                checks++;
                if (!$onehot(sel)) begin
                    errors++;
                    $display("FAIL random_onehot: got %b expected one-hot", sel);
                end
            end
        end
        $display("scenario random: cycles=%0d sel=%b", cyc, sel);
    endtask

    initial begin
        test_reset();
        test_clean_step();
        test_bounce();
        test_travel();
        test_fault_timeout();
        test_multi_reset();
        test_swap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
